uart_rx_cfg: RTL and testbench
==============================

// Module: uart_rx_cfg
// PURPOSE
//  Parametrised asynchronous serial receiver: configurable data width, parity, stop bits
//  and baud divisor. 3-sample majority vote at mid-bit, false-start rejection, and
//  parity/framing/break/overrun flags. Holding register with valid/ready handshake.
//  Sits between the board RX pin and a consumer: echo loop, FIFO or command parser.
// PARAMETERS
//  BAUD_DIV   104  clk cycles per bit (12 MHz / 115200); >= 8
//  DATA_BITS  8    data bits per frame, 5..9, LSB first
//  PARITY     0    0 = none, 1 = even, 2 = odd
//  STOP_BITS  1    1 or 2
// PORTS
//  clk         in   1          system clock
//  rstn        in   1          reset, synchronous, active-low
//  rx          in   1          serial line, idle high, asynchronous
//  ready       in   1          consumer accepts data this cycle
//  valid       out  1          data/flags hold a received frame
//  data        out  DATA_BITS  received word
//  parity_err  out  1          frame parity mismatch; qualified by valid
//  frame_err   out  1          a stop bit sampled 0; qualified by valid
//  brk         out  1          break: all data, parity and stop bits 0; qualified by valid
//  overrun     out  1          a frame was dropped because holding register was full
// BEHAVIOUR
//  - Reset: valid=0, data=0, all flags=0, FSM=IDLE, counters=0, rx synchronizer preset to 1.
//  - rx passes through a 2-flop synchronizer (rx_s); all decisions use rx_s.
//  - Bit timer: counts 0..BAUD_DIV-1 per bit. H = BAUD_DIV/2.
//    Samples are taken at counts H-1, H and H+1; the bit value is the majority of the three.
//  - FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> DONE -> IDLE; WAITIDLE is entered on a
//    framing error.
//    IDLE: timer cleared. A 1->0 edge on rx_s causes the transition to START with timer=0.
//    START: if the majority vote = 1, it is a false start and the FSM returns to IDLE with
//      no output. Otherwise the FSM runs to count BAUD_DIV-1 and moves to DATA.
//    DATA: DATA_BITS bits, shifted in LSB first. After the last bit the FSM moves to PARITY
//      if PARITY!=0, else to STOP.
//    PARITY: one bit. parity_err = (XOR(data)^bit) != (PARITY==2).
//    STOP: STOP_BITS bits. Any stop bit voted 0 sets frame_err.
//      The FSM leaves STOP at the decision sample of the last stop bit, not at the bit end,
//      to tolerate clock skew.
//    DONE (1 cycle): the frame is loaded into the holding register; see the handshake rules.
//      The FSM then enters WAITIDLE if frame_err, else IDLE.
//    WAITIDLE: the FSM stays until rx_s=1, then enters IDLE. A break therefore produces
//      exactly one frame.
//  - Handshake:
//    Load: at DONE, if valid=0 or (valid & ready), data and flags load and valid=1 on the
//      next cycle. Latency is 2 clk from the last-stop decision sample to valid=1.
//    Consume: valid & ready with no load in the same cycle causes valid=0 on the next cycle.
//    Simultaneous consume + load: the new frame replaces the old one and valid stays 1.
//    Full: at DONE with valid=1 & ready=0, the new frame is discarded, overrun=1, and the
//      held data is unchanged.
//    overrun is sticky until the next accepted handshake (valid & ready), then clears.
//  - data, parity_err, frame_err and brk are stable while valid=1 & ready=0.
//  - rstn=0 mid-frame: the partial frame is discarded. After rstn returns high, the next
//    falling edge starts a fresh frame.
// TESTING (BAUD_DIV=104 unless stated)
//  1. 8N1, send 0x55 then 0xA3, ready=1 -> valid pulses once per frame; data=0x55 then
//     0xA3; no flags set.
//  2. PARITY=1, 8E1: send 0x07 with parity bit 1 (correct) -> parity_err=0. Send 0x07 with
//     parity bit 0 -> data=0x07, parity_err=1.
//  3. 8N2 with second stop bit 0 -> frame_err=1. Line held low for 3 frame times -> one
//     frame, data=0x00, brk=1, frame_err=1. No further frame until rx returns high.
//  4. ready=0; send 0x11, 0x22 -> data=0x11, overrun=1. Raise ready for 1 cycle -> valid=0
//     and overrun=0 next cycle.
//  5. 40-cycle low glitch on idle line -> false start, no valid. Single-cycle spike at mid-bit
//     inside 0xFF -> data=0xFF (majority vote).
//  6. DATA_BITS=5, BAUD_DIV=16: send 0x1B -> data=0x1B. rstn pulse mid-frame -> no valid;
//     next frame 0x0A received correctly.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: asynchronous serial receiver with configurable width, parity, stop bits, baud divisor.
// Latency: valid rises 2 clk after the decision sample of the last stop bit.
// Backpressure: one-entry holding register; a frame arriving while it is full is dropped and flagged.
//
// Ports:
//   clk         system clock
//   rstn        synchronous active-low reset
//   rx          serial line, idle high, asynchronous to clk
//   ready       consumer accepts the held frame this cycle
//   valid       holding register contains a frame
//   data        received word, LSB first on the line
//   parity_err  parity mismatch of the held frame (qualified by valid)
//   frame_err   a stop bit of the held frame was sampled 0 (qualified by valid)
//   brk         held frame was all zeros including parity and stop bits (qualified by valid)
//   overrun     sticky: a frame was dropped, cleared by the next accepted handshake
module uart_rx_cfg #(
  parameter int BAUD_DIV  = 104,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 rx,
  input  logic                 ready,
  output logic                 valid,
  output logic [DATA_BITS-1:0] data,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 brk,
  output logic                 overrun
);

  localparam int CW = $clog2(BAUD_DIV);

  // Bit timer landmarks: three samples around mid-bit, the vote is taken at the third.
  localparam logic [CW-1:0] C_S0   = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] C_S1   = CW'(BAUD_DIV / 2);
  localparam logic [CW-1:0] C_DEC  = CW'(BAUD_DIV / 2 + 1);
  localparam logic [CW-1:0] C_LAST = CW'(BAUD_DIV - 1);

  localparam logic [3:0] BIT_LAST  = 4'(DATA_BITS - 1);
  localparam logic       STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic       ODD_PAR   = (PARITY == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_DONE,
    S_WAITIDLE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Input synchronizer and edge detector
  logic r_rx_meta;
  logic r_rx_s;
  logic r_rx_prev;

  // Bit timing and sampling
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_s0;
  logic          r_s1;
  logic [3:0]    r_bitcnt;
  logic          r_stopcnt;

  // Frame being assembled
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_err;
  logic                 r_frm_err;
  logic                 r_any_one;

  // Holding register
  logic                 r_valid;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_pe;
  logic                 r_fe;
  logic                 r_brk;
  logic                 r_ovr;

  logic w_fall;
  logic w_vote;
  logic w_at_dec;
  logic w_at_end;
  logic w_done;
  logic w_load;
  logic w_take;

  assign w_fall   = r_rx_prev & ~r_rx_s;
  // Majority of the two stored samples and the live third sample.
  assign w_vote   = (r_s0 & r_s1) | (r_s0 & r_rx_s) | (r_s1 & r_rx_s);
  assign w_at_dec = (r_cnt == C_DEC);
  assign w_at_end = (r_cnt == C_LAST);
  assign w_done   = (r_state == S_DONE);
  assign w_load   = w_done & (~r_valid | ready);
  assign w_take   = r_valid & ready;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state and bit timer
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = w_at_end ? '0 : r_cnt + 1'b1;

    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (w_fall) begin
          w_state_nxt = S_START;
        end
      end

      S_START: begin
        if (w_at_dec && w_vote) begin
          // Line was back high at mid-bit: a glitch, not a start bit.
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (w_at_end) begin
          w_state_nxt = S_DATA;
        end
      end

      S_DATA: begin
        if (w_at_end && (r_bitcnt == BIT_LAST)) begin
          w_state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
        end
      end

      S_PARITY: begin
        if (w_at_end) begin
          w_state_nxt = S_STOP;
        end
      end

      S_STOP: begin
        // Leave at mid-bit of the last stop bit so a slightly fast
        // transmitter's next start edge is not missed.
        if (w_at_dec && (r_stopcnt == STOP_LAST)) begin
          w_state_nxt = S_DONE;
        end
      end

      S_DONE: begin
        w_cnt_nxt   = '0;
        w_state_nxt = r_frm_err ? S_WAITIDLE : S_IDLE;
      end

      S_WAITIDLE: begin
        // A held-low line (break) must not be re-parsed as more frames.
        w_cnt_nxt = '0;
        if (r_rx_s) begin
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Synchronizer, sampling and frame assembly
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_prev <= 1'b1;
      r_s0      <= 1'b1;
      r_s1      <= 1'b1;
      r_bitcnt  <= '0;
      r_stopcnt <= 1'b0;
      r_shift   <= '0;
      r_par_err <= 1'b0;
      r_frm_err <= 1'b0;
      r_any_one <= 1'b0;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
      r_rx_prev <= r_rx_s;

      if (r_cnt == C_S0) begin
        r_s0 <= r_rx_s;
      end
      if (r_cnt == C_S1) begin
        r_s1 <= r_rx_s;
      end

      case (r_state)
        S_START: begin
          r_bitcnt  <= '0;
          r_stopcnt <= 1'b0;
          r_par_err <= 1'b0;
          r_frm_err <= 1'b0;
          r_any_one <= 1'b0;
        end

        S_DATA: begin
          if (w_at_dec) begin
            r_shift   <= {w_vote, r_shift[DATA_BITS-1:1]};
            r_any_one <= r_any_one | w_vote;
          end
          if (w_at_end) begin
            r_bitcnt <= r_bitcnt + 4'd1;
          end
        end

        S_PARITY: begin
          if (w_at_dec) begin
            r_par_err <= ((^r_shift) ^ w_vote) != ODD_PAR;
            r_any_one <= r_any_one | w_vote;
          end
        end

        S_STOP: begin
          if (w_at_dec) begin
            if (!w_vote) begin
              r_frm_err <= 1'b1;
            end
            r_any_one <= r_any_one | w_vote;
          end
          if (w_at_end) begin
            r_stopcnt <= 1'b1;
          end
        end

        default: begin
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Holding register and handshake
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_pe    <= 1'b0;
      r_fe    <= 1'b0;
      r_brk   <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      // A load in the same cycle as a consume replaces the frame; valid stays high.
      if (w_load) begin
        r_valid <= 1'b1;
        r_data  <= r_shift;
        r_pe    <= r_par_err;
        r_fe    <= r_frm_err;
        r_brk   <= ~r_any_one;
      end else if (w_take) begin
        r_valid <= 1'b0;
      end

      if (w_done && r_valid && !ready) begin
        r_ovr <= 1'b1;
      end else if (w_take) begin
        r_ovr <= 1'b0;
      end
    end
  end

  assign valid      = r_valid;
  assign data       = r_data;
  assign parity_err = r_pe;
  assign frame_err  = r_fe;
  assign brk        = r_brk;
  assign overrun    = r_ovr;

endmodule

// File: tb/tb_uart_rx_cfg.sv
module tb_uart_rx_cfg;

  logic       clk = 1'b0;
  logic       rstn;
  logic [3:0] rx_line;
  logic [3:0] rdy;
  logic [3:0] vld;
  logic [3:0] pe;
  logic [3:0] fe;
  logic [3:0] bk;
  logic [3:0] ov;
  logic [7:0] dat_a;
  logic [7:0] dat_b;
  logic [7:0] dat_c;
  logic [4:0] dat_d;
  logic [8:0] dat_w [4];

  int n_vec = 0;
  int n_err = 0;
  int acc [4] = '{0, 0, 0, 0};
  logic [8:0] last_dat [4];
  logic [2:0] last_flg [4];

  always #5 clk = ~clk;

  // 8N1, 104
  uart_rx_cfg #(.BAUD_DIV(104), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
    .clk(clk), .rstn(rstn), .rx(rx_line[0]), .ready(rdy[0]), .valid(vld[0]), .data(dat_a),
    .parity_err(pe[0]), .frame_err(fe[0]), .brk(bk[0]), .overrun(ov[0]));
  // 8E1, 104
  uart_rx_cfg #(.BAUD_DIV(104), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_b (
    .clk(clk), .rstn(rstn), .rx(rx_line[1]), .ready(rdy[1]), .valid(vld[1]), .data(dat_b),
    .parity_err(pe[1]), .frame_err(fe[1]), .brk(bk[1]), .overrun(ov[1]));
  // 8N2, 104
  uart_rx_cfg #(.BAUD_DIV(104), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_c (
    .clk(clk), .rstn(rstn), .rx(rx_line[2]), .ready(rdy[2]), .valid(vld[2]), .data(dat_c),
    .parity_err(pe[2]), .frame_err(fe[2]), .brk(bk[2]), .overrun(ov[2]));
  // 5N1, 16
  uart_rx_cfg #(.BAUD_DIV(16), .DATA_BITS(5), .PARITY(0), .STOP_BITS(1)) u_d (
    .clk(clk), .rstn(rstn), .rx(rx_line[3]), .ready(rdy[3]), .valid(vld[3]), .data(dat_d),
    .parity_err(pe[3]), .frame_err(fe[3]), .brk(bk[3]), .overrun(ov[3]));

  assign dat_w[0] = {1'b0, dat_a};
  assign dat_w[1] = {1'b0, dat_b};
  assign dat_w[2] = {1'b0, dat_c};
  assign dat_w[3] = {4'b0, dat_d};

  // Record every accepted handshake per instance.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (vld[i] && rdy[i]) begin
        acc[i]      <= acc[i] + 1;
        last_dat[i] <= dat_w[i];
        last_flg[i] <= {pe[i], fe[i], bk[i]};
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Wait n clocks, ending 1 time unit after the edge.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive nb bits of 'bits' onto line w, bit 0 first, baud clocks each.
  task automatic send_bits(input int w, input int baud, input int nb, input logic [15:0] bits);
    for (int k = 0; k < nb; k++) begin
      rx_line[w] = bits[k];
      cyc(baud);
    end
  endtask

  int base;

  initial begin
    rstn    = 1'b0;
    rx_line = 4'hF;
    rdy     = 4'hF;
    cyc(5);

    // Reset state
    chk("rst_valid", {28'd0, vld}, 32'h0);
    chk("rst_flags", {16'd0, pe, fe, bk, ov}, 32'h0);
    chk("rst_data_a", {24'd0, dat_a}, 32'h0);
    rstn = 1'b1;
    cyc(10);

    // 8N1 back-to-back frames, ready high
    base = acc[0];
    send_bits(0, 104, 10, {6'b0, 1'b1, 8'h55, 1'b0});
    cyc(50);
    chk("n1_cnt1", acc[0] - base, 1);
    chk("n1_dat1", {23'd0, last_dat[0]}, 32'h55);
    chk("n1_flg1", {29'd0, last_flg[0]}, 32'h0);
    send_bits(0, 104, 10, {6'b0, 1'b1, 8'hA3, 1'b0});
    cyc(50);
    chk("n1_cnt2", acc[0] - base, 2);
    chk("n1_dat2", {23'd0, last_dat[0]}, 32'hA3);
    chk("n1_flg2", {29'd0, last_flg[0]}, 32'h0);
    chk("n1_vld_low", {31'd0, vld[0]}, 32'h0);
    chk("n1_ovr", {31'd0, ov[0]}, 32'h0);

    // 8E1: correct parity, then wrong parity
    base = acc[1];
    send_bits(1, 104, 11, {5'b0, 1'b1, 1'b1, 8'h07, 1'b0});
    cyc(50);
    chk("e1_cnt1", acc[1] - base, 1);
    chk("e1_dat1", {23'd0, last_dat[1]}, 32'h07);
    chk("e1_flg1", {29'd0, last_flg[1]}, 32'h0);
    send_bits(1, 104, 11, {5'b0, 1'b1, 1'b0, 8'h07, 1'b0});
    cyc(50);
    chk("e1_cnt2", acc[1] - base, 2);
    chk("e1_dat2", {23'd0, last_dat[1]}, 32'h07);
    chk("e1_flg2", {29'd0, last_flg[1]}, 32'h4);

    // 8N2: second stop bit low -> framing error
    base = acc[2];
    send_bits(2, 104, 11, {5'b0, 1'b0, 1'b1, 8'h5A, 1'b0});
    rx_line[2] = 1'b1;
    cyc(200);
    chk("n2_cnt", acc[2] - base, 1);
    chk("n2_dat", {23'd0, last_dat[2]}, 32'h5A);
    chk("n2_flg", {29'd0, last_flg[2]}, 32'h2);

    // Break: line low for three frame times -> exactly one frame
    base = acc[2];
    rx_line[2] = 1'b0;
    cyc(3 * 12 * 104);
    chk("brk_cnt", acc[2] - base, 1);
    chk("brk_dat", {23'd0, last_dat[2]}, 32'h00);
    chk("brk_flg", {29'd0, last_flg[2]}, 32'h3);
    rx_line[2] = 1'b1;
    cyc(2 * 104);
    chk("brk_idle_cnt", acc[2] - base, 1);
    send_bits(2, 104, 11, {5'b0, 2'b11, 8'h3C, 1'b0});
    cyc(50);
    chk("brk_rec_cnt", acc[2] - base, 2);
    chk("brk_rec_dat", {23'd0, last_dat[2]}, 32'h3C);
    chk("brk_rec_flg", {29'd0, last_flg[2]}, 32'h0);

    // Overrun: ready low, two frames
    rdy[0] = 1'b0;
    base = acc[0];
    send_bits(0, 104, 10, {6'b0, 1'b1, 8'h11, 1'b0});
    cyc(2 * 104);
    send_bits(0, 104, 10, {6'b0, 1'b1, 8'h22, 1'b0});
    cyc(2 * 104);
    chk("ovr_vld", {31'd0, vld[0]}, 32'h1);
    chk("ovr_dat", {24'd0, dat_a}, 32'h11);
    chk("ovr_flag", {31'd0, ov[0]}, 32'h1);
    chk("ovr_nocnt", acc[0] - base, 0);
    rdy[0] = 1'b1;
    cyc(1);
    rdy[0] = 1'b0;
    chk("ovr_vld_clr", {31'd0, vld[0]}, 32'h0);
    chk("ovr_flag_clr", {31'd0, ov[0]}, 32'h0);
    rdy[0] = 1'b1;
    cyc(20);

    // False start: 40-cycle low glitch
    base = acc[0];
    rx_line[0] = 1'b0;
    cyc(40);
    rx_line[0] = 1'b1;
    cyc(3 * 104);
    chk("glitch_cnt", acc[0] - base, 0);
    chk("glitch_vld", {31'd0, vld[0]}, 32'h0);

    // Single-cycle spike in the middle of data bit 3 of 0xFF
    send_bits(0, 104, 1, 16'h0000);
    rx_line[0] = 1'b1;
    cyc(3 * 104 + 52);
    rx_line[0] = 1'b0;
    cyc(1);
    rx_line[0] = 1'b1;
    cyc(8 * 104 - (3 * 104 + 52 + 1) + 104);
    cyc(20);
    chk("spike_cnt", acc[0] - base, 1);
    chk("spike_dat", {23'd0, last_dat[0]}, 32'hFF);
    chk("spike_flg", {29'd0, last_flg[0]}, 32'h0);

    // 5N1 at BAUD_DIV=16
    base = acc[3];
    send_bits(3, 16, 7, {9'b0, 1'b1, 5'h1B, 1'b0});
    cyc(20);
    chk("d5_cnt1", acc[3] - base, 1);
    chk("d5_dat1", {23'd0, last_dat[3]}, 32'h1B);

    // Reset in the middle of a frame
    send_bits(3, 16, 3, 16'b010);
    rstn       = 1'b0;
    rx_line[3] = 1'b1;
    cyc(3);
    rstn = 1'b1;
    cyc(4 * 16);
    chk("d5_rst_cnt", acc[3] - base, 1);
    chk("d5_rst_vld", {31'd0, vld[3]}, 32'h0);
    send_bits(3, 16, 7, {9'b0, 1'b1, 5'h0A, 1'b0});
    cyc(20);
    chk("d5_cnt2", acc[3] - base, 2);
    chk("d5_dat2", {23'd0, last_dat[3]}, 32'h0A);
    chk("d5_flg2", {29'd0, last_flg[3]}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
